// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_gen
// Description : VGA raster timing generator. Free-running horizontal and
//               vertical counters with registered hsync/vsync/bright decoded
//               from next-state counts, so the decodes line up with the
//               counters they describe. frame_start pulses for one clk after
//               the (H_TOTAL-1, V_TOTAL-1) -> (0,0) wrap.
//               Macro VGA_PIX_DIV_EN: when defined, pix_en is an internal
//               divide-by-two toggle; when undefined, pix_en is tied high.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
  parameter int H_TOTAL      = 800,
  parameter int H_SYNC       = 96,
  parameter int H_DISP_START = 158,
  parameter int H_DISP_END   = 745,
  parameter int V_TOTAL      = 525,
  parameter int V_DISP       = 480,
  parameter int V_SYNC_START = 490,
  parameter int V_SYNC_END   = 492
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [9:0] hcount,
  output logic [9:0] vcount,
  output logic       hsync,
  output logic       vsync,
  output logic       bright,
  output logic       pix_en,
  output logic       frame_start
);

  // 10-bit copies of the timing parameters so every compare is unsigned 10-bit
  localparam logic [9:0] c_h_max        = 10'(H_TOTAL - 1);
  localparam logic [9:0] c_v_max        = 10'(V_TOTAL - 1);
  localparam logic [9:0] c_h_sync       = 10'(H_SYNC);
  localparam logic [9:0] c_h_disp_start = 10'(H_DISP_START);
  localparam logic [9:0] c_h_disp_end   = 10'(H_DISP_END);
  localparam logic [9:0] c_v_disp       = 10'(V_DISP);
  localparam logic [9:0] c_v_sync_start = 10'(V_SYNC_START);
  localparam logic [9:0] c_v_sync_end   = 10'(V_SYNC_END);

  logic [9:0] w_h_next;
  logic [9:0] w_v_next;
  logic       w_h_wrap;
  logic       w_frame_wrap;
  logic       w_hsync_next;
  logic       w_vsync_next;
  logic       w_bright_next;

`ifdef VGA_PIX_DIV_EN
  logic r_pix_en;

  // Divide-by-two pixel tick: low in reset, high on the first edge after release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pix_en <= 1'b0;
    end else begin
      r_pix_en <= ~r_pix_en;
    end
  end

  assign pix_en = r_pix_en;
`else
  assign pix_en = 1'b1;
`endif

  // Wrap conditions only matter on pixel-tick edges
  assign w_h_wrap     = pix_en && (hcount == c_h_max);
  assign w_frame_wrap = w_h_wrap && (vcount == c_v_max);

  // Next-state counters; hold when no pixel tick
  always_comb begin
    w_h_next = hcount;
    w_v_next = vcount;
    if (pix_en) begin
      if (w_h_wrap) begin
        w_h_next = 10'd0;
        w_v_next = (vcount == c_v_max) ? 10'd0 : vcount + 10'd1;
      end else begin
        w_h_next = hcount + 10'd1;
      end
    end
  end

  // Decode the counts that will be presented next cycle (zero relative latency)
  assign w_hsync_next  = (w_h_next >= c_h_sync);
  assign w_vsync_next  = !((w_v_next >= c_v_sync_start) && (w_v_next < c_v_sync_end));
  assign w_bright_next = (w_h_next >= c_h_disp_start) && (w_h_next < c_h_disp_end) &&
                         (w_v_next < c_v_disp);

  // Counter, sync/bright and frame-start registers; reset values match decode of (0,0)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcount      <= 10'd0;
      vcount      <= 10'd0;
      hsync       <= 1'b0;
      vsync       <= 1'b1;
      bright      <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      hcount      <= w_h_next;
      vcount      <= w_v_next;
      hsync       <= w_hsync_next;
      vsync       <= w_vsync_next;
      bright      <= w_bright_next;
      frame_start <= w_frame_wrap;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_timing_gen
// Description : Self-checking bench for vga_timing_gen. A default-parameter
//               instance covers horizontal behaviour; a short-line instance
//               (H_TOTAL=20, default vertical timing) reaches vsync and
//               frame boundaries quickly. Expected outputs are derived from
//               the number of clk edges since reset release.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

  logic clk;
  logic rst_n;

  logic [9:0] m_hcount, m_vcount, s_hcount, s_vcount;
  logic       m_hsync, m_vsync, m_bright, m_pix_en, m_frame_start;
  logic       s_hsync, s_vsync, s_bright, s_pix_en, s_frame_start;

  int checks   = 0;
  int failures = 0;
  int n_edges  = 0;
  bit checks_on = 0;

`ifdef VGA_PIX_DIV_EN
  localparam int TPE = 2;
`else
  localparam int TPE = 1;
`endif

  vga_timing_gen u_dut (
    .clk(clk), .rst_n(rst_n), .hcount(m_hcount), .vcount(m_vcount),
    .hsync(m_hsync), .vsync(m_vsync), .bright(m_bright), .pix_en(m_pix_en),
    .frame_start(m_frame_start)
  );

  vga_timing_gen #(
    .H_TOTAL(20), .H_SYNC(4), .H_DISP_START(6), .H_DISP_END(17)
  ) u_dut_s (
    .clk(clk), .rst_n(rst_n), .hcount(s_hcount), .vcount(s_vcount),
    .hsync(s_hsync), .vsync(s_vsync), .bright(s_bright), .pix_en(s_pix_en),
    .frame_start(s_frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Clk edges seen since reset release
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) n_edges <= 0;
    else        n_edges <= n_edges + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected {hcount,vcount,hsync,vsync,bright,pix_en,frame_start} after n edges
  function automatic logic [24:0] model(input int n, input int ht, input int hs,
                                        input int hds, input int hde, input int vt,
                                        input int vd, input int vss, input int vse);
    int   ticks, h, v;
    logic pe, fs, tick_edge, e_hs, e_vs, e_br;
`ifdef VGA_PIX_DIV_EN
    ticks     = n / 2;
    pe        = (n % 2) == 1;
    tick_edge = (n % 2) == 0;
`else
    ticks     = n;
    pe        = 1'b1;
    tick_edge = 1'b1;
`endif
    h    = ticks % ht;
    v    = (ticks / ht) % vt;
    fs   = (ticks > 0) && tick_edge && ((ticks % (ht * vt)) == 0);
    e_hs = (h >= hs);
    e_vs = !((v >= vss) && (v < vse));
    e_br = (h >= hds) && (h < hde) && (v < vd);
    return {10'(h), 10'(v), e_hs, e_vs, e_br, pe, fs};
  endfunction

  task automatic cmp_inst(input string p, input logic [24:0] act, input logic [24:0] exp);
    chk({p, "hcount"},      32'(act[24:15]), 32'(exp[24:15]));
    chk({p, "vcount"},      32'(act[14:5]),  32'(exp[14:5]));
    chk({p, "hsync"},       32'(act[4]),     32'(exp[4]));
    chk({p, "vsync"},       32'(act[3]),     32'(exp[3]));
    chk({p, "bright"},      32'(act[2]),     32'(exp[2]));
    chk({p, "pix_en"},      32'(act[1]),     32'(exp[1]));
    chk({p, "frame_start"}, 32'(act[0]),     32'(exp[0]));
  endtask

  // Cycle-by-cycle comparison of both instances against the model
  always @(negedge clk) begin
    if (checks_on) begin
      cmp_inst("m_", {m_hcount, m_vcount, m_hsync, m_vsync, m_bright, m_pix_en, m_frame_start},
               model(n_edges, 800, 96, 158, 745, 525, 480, 490, 492));
      cmp_inst("s_", {s_hcount, s_vcount, s_hsync, s_vsync, s_bright, s_pix_en, s_frame_start},
               model(n_edges, 20, 4, 6, 17, 525, 480, 490, 492));
    end
  end

  // Advance to the negedge following pixel tick t (bounded wait)
  task automatic wait_tick(input int t, input int extra);
    int guard = 0;
    while (n_edges < TPE * t + extra && guard < 100000) begin
      @(negedge clk);
      guard++;
    end
    chk("wait_tick_reached", 32'(n_edges), 32'(TPE * t + extra));
  endtask

  task automatic chk_reset_vals(input string p, input logic [24:0] act);
    chk({p, "rst_hcount"}, 32'(act[24:15]), 0);
    chk({p, "rst_vcount"}, 32'(act[14:5]),  0);
    chk({p, "rst_hsync"},  32'(act[4]),     0);
    chk({p, "rst_vsync"},  32'(act[3]),     1);
    chk({p, "rst_bright"}, 32'(act[2]),     0);
`ifdef VGA_PIX_DIV_EN
    chk({p, "rst_pix_en"}, 32'(act[1]),     0);
`else
    chk({p, "rst_pix_en"}, 32'(act[1]),     1);
`endif
    chk({p, "rst_frame_start"}, 32'(act[0]), 0);
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks_on = 1'b1;
    chk_reset_vals("m_", {m_hcount, m_vcount, m_hsync, m_vsync, m_bright, m_pix_en, m_frame_start});
    @(negedge clk);
    rst_n = 1'b1;

    // First edges after release
`ifdef VGA_PIX_DIV_EN
    wait_tick(0, 1);
    chk("lit_m_pix_en_e1", 32'(m_pix_en), 1);
    chk("lit_m_hcount_e1", 32'(m_hcount), 0);
    wait_tick(1, 0);
    chk("lit_m_pix_en_e2", 32'(m_pix_en), 0);
    chk("lit_m_hcount_e2", 32'(m_hcount), 1);
`else
    wait_tick(1, 0);
    chk("lit_m_hcount_1", 32'(m_hcount), 1);
    wait_tick(2, 0);
    chk("lit_m_hcount_2", 32'(m_hcount), 2);
`endif

    // Horizontal decode boundaries on the default instance
    wait_tick(95, 0);  chk("lit_m_hsync_95", 32'(m_hsync), 0);
    wait_tick(96, 0);  chk("lit_m_hsync_96", 32'(m_hsync), 1);
                       chk("lit_m_hcount_96", 32'(m_hcount), 96);
    wait_tick(157, 0); chk("lit_m_bright_157", 32'(m_bright), 0);
    wait_tick(158, 0); chk("lit_m_bright_158", 32'(m_bright), 1);
    wait_tick(744, 0); chk("lit_m_bright_744", 32'(m_bright), 1);
    wait_tick(745, 0); chk("lit_m_bright_745", 32'(m_bright), 0);
    wait_tick(799, 0); chk("lit_m_hcount_799", 32'(m_hcount), 799);
                       chk("lit_m_vcount_799", 32'(m_vcount), 0);
    wait_tick(800, 0); chk("lit_m_hcount_800", 32'(m_hcount), 0);
                       chk("lit_m_vcount_800", 32'(m_vcount), 1);

    // Asynchronous reset mid-frame at short-line instance (10,300)
    wait_tick(6010, 0);
    chk("lit_s_hcount_pre_rst", 32'(s_hcount), 10);
    chk("lit_s_vcount_pre_rst", 32'(s_vcount), 300);
    chk("lit_m_hcount_pre_rst", 32'(m_hcount), 410);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("m_", {m_hcount, m_vcount, m_hsync, m_vsync, m_bright, m_pix_en, m_frame_start});
    chk_reset_vals("s_", {s_hcount, s_vcount, s_hsync, s_vsync, s_bright, s_pix_en, s_frame_start});
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    wait_tick(1, 0);   chk("lit_s_frame_start_restart", 32'(s_frame_start), 0);

    // Vertical sync boundaries (short lines: line L starts at tick 20*L)
    wait_tick(9780, 0); chk("lit_s_vsync_489", 32'(s_vsync), 1);
                        chk("lit_s_vcount_489", 32'(s_vcount), 489);
    wait_tick(9800, 0); chk("lit_s_vsync_490", 32'(s_vsync), 0);
    wait_tick(9820, 0); chk("lit_s_vsync_491", 32'(s_vsync), 0);
    wait_tick(9840, 0); chk("lit_s_vsync_492", 32'(s_vsync), 1);

    // Frame boundaries: 20*525 = 10500 ticks per frame
    wait_tick(10499, 0); chk("lit_s_fs_10499", 32'(s_frame_start), 0);
                         chk("lit_s_hcount_10499", 32'(s_hcount), 19);
                         chk("lit_s_vcount_10499", 32'(s_vcount), 524);
    wait_tick(10500, 0); chk("lit_s_fs_10500", 32'(s_frame_start), 1);
                         chk("lit_s_hcount_10500", 32'(s_hcount), 0);
                         chk("lit_s_vcount_10500", 32'(s_vcount), 0);
    wait_tick(10500, 1); chk("lit_s_fs_10500_next", 32'(s_frame_start), 0);
    wait_tick(20999, 0); chk("lit_s_fs_20999", 32'(s_frame_start), 0);
    wait_tick(21000, 0); chk("lit_s_fs_21000", 32'(s_frame_start), 1);
                         chk("lit_m_fs_21000", 32'(m_frame_start), 0);
    wait_tick(21000, 1); chk("lit_s_fs_21000_next", 32'(s_frame_start), 0);

    repeat (5) @(negedge clk);
    checks_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
